lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of data-memory word 0.
REQ-002 SHALL have ports, clock and reset first (one clock; reset is asynchronous and active-high):
- i_clk  in  1  clock; all state changes on the rising edge
- i_rst  in  1  asynchronous active-high reset
- in_lsu_valid  in  1  request valid
- out_lsu_ready  out  1  LSU can accept a request
- in_lsu_is_store  in  1  1 = store, 0 = load
- in_lsu_funct3  in  3  RV32I load/store funct3
- in_lsu_addr  in  32  byte address
- in_lsu_wdata  in  32  store data, right-aligned
- out_lsu_rdata  out  32  extended load result
- out_lsu_done  out  1  one-cycle completion pulse
- out_lsu_err  out  1  one-cycle fault pulse, coincident with done
- out_mem_addr  out  10  data-memory word index
- out_mem_re_web  out  1  1 = read, 0 = write
- out_mem_write_data  out  32  lane-replicated store data
- out_mem_byte_en  out  4  active byte lanes
- in_mem_data  in  32  memory read word, valid the cycle after the address is presented

Function
REQ-003 SHALL implement the FSM IDLE -> ACCESS -> RESP -> IDLE, and IDLE -> FAULT -> IDLE.
REQ-004 SHALL drive out_lsu_ready = 1 only in IDLE; a request is accepted on a rising edge with valid & ready, and all request fields are captured into registers.
REQ-005 SHALL compute off = addr - BASE_ADDR; the request is legal only when off < 4096, funct3 is legal, and the access is aligned.
- Legal loads: LB, LH, LW, LBU, LHU.
- Legal stores: SB, SH, SW.
- Aligned: halfword needs off[0] = 0; word needs off[1:0] = 0.
REQ-006 SHALL go from IDLE to FAULT on an illegal request; FAULT asserts done = 1 and err = 1 for one cycle and performs no memory access.
REQ-007 SHALL go from IDLE to ACCESS on a legal request; in ACCESS, for exactly one cycle, it drives:
- out_mem_addr = off[11:2];
- out_mem_re_web = ~is_store;
- out_mem_byte_en: byte = 1 << off[1:0]; half = 4'b0011 << off[1:0]; word = 4'b1111;
- out_mem_write_data: byte replicated to all 4 lanes; half replicated to both halves; word unchanged.
REQ-008 SHALL, outside ACCESS, drive out_mem_re_web = 1 and out_mem_byte_en = 0, and hold out_mem_addr at its last value.
REQ-009 SHALL spend one cycle in RESP, asserting done = 1 and err = 0.
- For loads, it selects the lane(s) of in_mem_data given by off[1:0].
- LB and LH sign-extend; LBU and LHU zero-extend.
- The result is registered into out_lsu_rdata at the end of RESP and held until the next load completes.
REQ-010 SHALL leave out_lsu_rdata unchanged for stores and faults.
REQ-011 SHALL give a latency from the accept edge to done of 2 cycles for a legal request and 1 cycle for a fault; maximum throughput is one request per 3 cycles.
REQ-012 SHALL ignore in_lsu_valid while not in IDLE; input changes there have no effect.

Reset
REQ-013 SHALL, while i_rst = 1, asynchronously force the following, independent of the clock:
- state = IDLE;
- out_lsu_ready = 1;
- out_lsu_done = 0 and out_lsu_err = 0;
- out_lsu_rdata = 0;
- out_mem_addr = 0;
- out_mem_re_web = 1;
- out_mem_byte_en = 0;
- out_mem_write_data = 0.
REQ-014 SHALL cause no memory write and no done pulse for an in-flight request when reset is asserted in ACCESS or RESP; the request is dropped.

Structure
REQ-015 SHALL place the following in shared package lsu_pkg:
- the FSM state enum;
- funct3 constants: LB/LH/LW/LBU/LHU and SB/SH/SW;
- the memory-span constant 4096.
REQ-016 SHALL implement lane selection and sign/zero extension in one combinational sub-module, lsu_load_ext, instantiated once.

Verification
REQ-017 SW at 0x08 with wdata 0xDEADBEEF -> in ACCESS: mem_addr 2, re_web 0, byte_en 4'b1111, write_data 0xDEADBEEF; done 2 cycles after accept.
REQ-018 SB at 0x0D with wdata 0x000000A5 -> mem_addr 3, byte_en 4'b0010, write_data 0xA5A5A5A5; SH at 0x0E with wdata 0x1234 -> byte_en 4'b1100, write_data 0x12341234.
REQ-019 Mem word 0x80FF1234 at index 3 -> results:
- LB at 0x0F -> rdata 0xFFFFFF80;
- LBU at 0x0F -> rdata 0x00000080;
- LH at 0x0C -> rdata 0x00001234.
REQ-020 Faults:
- LW at 0x02 -> FAULT: done = 1 and err = 1 one cycle after accept; byte_en stays 0, re_web stays 1, rdata unchanged.
- LW at 0x1000 -> same fault response.
REQ-021 valid held high with back-to-back legal requests -> ready high only in IDLE; accepts spaced exactly 3 cycles apart; one done per request.
REQ-022 SW in flight, i_rst pulsed mid-ACCESS -> re_web = 1 and byte_en = 0 immediately; no done; memory content unchanged; ready = 1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states,
// RV32I load/store funct3 codes and the data-memory span.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2,
        ST_FAULT  = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [31:0] MEM_SPAN = 32'd4096;

    // A request is legal when the opcode is a known load/store, the access is
    // naturally aligned and the offset lands inside the data memory.
    function automatic logic is_legal(input logic       is_store,
                                      input logic [2:0] f3,
                                      input logic [31:0] off);
        logic f3_ok;
        logic aligned;
        if (is_store)
            f3_ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        else
            f3_ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                    (f3 == F3_LBU) || (f3 == F3_LHU);
        case (f3[1:0])
            2'b01:   aligned = ~off[0];
            2'b10:   aligned = (off[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        return f3_ok && aligned && (off < MEM_SPAN);
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Picks the addressed byte/halfword out of a memory word and sign- or
// zero-extends it according to the load funct3.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_off)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

        case (i_funct3)
            F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_data = {{16{w_half[15]}}, w_half};
            F3_LBU:  o_data = {24'b0, w_byte};
            F3_LHU:  o_data = {16'b0, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one request at a time, performs a single-cycle
// access to a word-organised data memory and returns an extended load result.
module lsu
    import lsu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
)
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        in_lsu_valid,
    output logic        out_lsu_ready,
    input  logic        in_lsu_is_store,
    input  logic [2:0]  in_lsu_funct3,
    input  logic [31:0] in_lsu_addr,
    input  logic [31:0] in_lsu_wdata,
    output logic [31:0] out_lsu_rdata,
    output logic        out_lsu_done,
    output logic        out_lsu_err,
    output logic [9:0]  out_mem_addr,
    output logic        out_mem_re_web,
    output logic [31:0] out_mem_write_data,
    output logic [3:0]  out_mem_byte_en,
    input  logic [31:0] in_mem_data
);

    lsu_state_e r_state;
    lsu_state_e w_next;

    logic        r_is_store;
    logic [2:0]  r_funct3;
    logic [11:0] r_off;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [9:0]  r_mem_addr;

    logic [31:0] w_off;
    logic        w_accept;
    logic        w_legal;
    logic [31:0] w_load;

    assign w_off    = in_lsu_addr - BASE_ADDR;
    assign w_accept = in_lsu_valid && (r_state == ST_IDLE);
    assign w_legal  = is_legal(in_lsu_is_store, in_lsu_funct3, w_off);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_next = w_legal ? ST_ACCESS : ST_FAULT;
            ST_ACCESS: w_next = ST_RESP;
            ST_RESP:   w_next = ST_IDLE;
            ST_FAULT:  w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // The memory address register only moves for legal requests so that it
    // holds its last value through faults and idle periods.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_is_store <= 1'b0;
            r_funct3   <= 3'b0;
            r_off      <= 12'b0;
            r_wdata    <= 32'b0;
            r_rdata    <= 32'b0;
            r_mem_addr <= 10'b0;
        end else begin
            if (w_accept) begin
                r_is_store <= in_lsu_is_store;
                r_funct3   <= in_lsu_funct3;
                r_off      <= w_off[11:0];
                r_wdata    <= in_lsu_wdata;
                if (w_legal)
                    r_mem_addr <= w_off[11:2];
            end
            if ((r_state == ST_RESP) && !r_is_store)
                r_rdata <= w_load;
        end
    end

    always_comb begin
        out_lsu_ready      = 1'b0;
        out_lsu_done       = 1'b0;
        out_lsu_err        = 1'b0;
        out_mem_re_web     = 1'b1;
        out_mem_byte_en    = 4'b0000;
        out_mem_write_data = 32'b0;
        case (r_state)
            ST_IDLE: out_lsu_ready = 1'b1;
            ST_ACCESS: begin
                out_mem_re_web = ~r_is_store;
                case (r_funct3[1:0])
                    2'b00: begin
                        out_mem_byte_en    = 4'b0001 << r_off[1:0];
                        out_mem_write_data = {4{r_wdata[7:0]}};
                    end
                    2'b01: begin
                        out_mem_byte_en    = 4'b0011 << r_off[1:0];
                        out_mem_write_data = {2{r_wdata[15:0]}};
                    end
                    default: begin
                        out_mem_byte_en    = 4'b1111;
                        out_mem_write_data = r_wdata;
                    end
                endcase
            end
            ST_RESP: out_lsu_done = 1'b1;
            ST_FAULT: begin
                out_lsu_done = 1'b1;
                out_lsu_err  = 1'b1;
            end
            default: out_lsu_ready = 1'b0;
        endcase
    end

    lsu_load_ext u_load_ext (
        .i_word   (in_mem_data),
        .i_off    (r_off[1:0]),
        .i_funct3 (r_funct3),
        .o_data   (w_load)
    );

    assign out_mem_addr  = r_mem_addr;
    assign out_lsu_rdata = r_rdata;

endmodule

// File: tb/tb_lsu.sv
// Randomised self-checking bench for the LSU: a transaction-level reference
// model plus a word-addressed data memory, with directed literal checks.
module tb_lsu;

    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lsuValid = 1'b0;
    logic        lsuIsStore = 1'b0;
    logic [2:0]  lsuFunct3 = 3'b0;
    logic [31:0] lsuAddr = 32'b0;
    logic [31:0] lsuWdata = 32'b0;
    logic        outReady;
    logic [31:0] outRdata;
    logic        outDone;
    logic        outErr;
    logic [9:0]  memAddr;
    logic        memReWeb;
    logic [31:0] memWriteData;
    logic [3:0]  memByteEn;
    logic [31:0] memRdata = 32'b0;

    int totalChecks = 0;
    int badChecks = 0;
    logic chkOn = 1'b0;

    always #5 clk = ~clk;

    lsu #(.BASE_ADDR(BASE)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .in_lsu_valid       (lsuValid),
        .out_lsu_ready      (outReady),
        .in_lsu_is_store    (lsuIsStore),
        .in_lsu_funct3      (lsuFunct3),
        .in_lsu_addr        (lsuAddr),
        .in_lsu_wdata       (lsuWdata),
        .out_lsu_rdata      (outRdata),
        .out_lsu_done       (outDone),
        .out_lsu_err        (outErr),
        .out_mem_addr       (memAddr),
        .out_mem_re_web     (memReWeb),
        .out_mem_write_data (memWriteData),
        .out_mem_byte_en    (memByteEn),
        .in_mem_data        (memRdata)
    );

    function automatic logic [31:0] initWord(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Access width in bytes, 0 when the funct3 is not a valid load/store.
    function automatic int accessSize(input logic st, input logic [2:0] f3);
        if (st) begin
            case (f3)
                3'd0: return 1;
                3'd1: return 2;
                3'd2: return 4;
                default: return 0;
            endcase
        end
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic reqLegal(input logic st, input logic [2:0] f3, input logic [31:0] off);
        int sz;
        sz = accessSize(st, f3);
        if (sz == 0) return 1'b0;
        if (off >= 32'd4096) return 1'b0;
        return (off % 32'(sz)) == 32'd0;
    endfunction

    function automatic logic [31:0] sizeMask(input int sz);
        return (sz == 1) ? 32'h0000_00FF : (sz == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] storeMerge(input logic [31:0] old, input logic [31:0] off,
                                               input int sz, input logic [31:0] wd);
        logic [31:0] m;
        logic [31:0] d;
        m = sizeMask(sz) << {off[1:0], 3'b000};
        d = wd << {off[1:0], 3'b000};
        return (old & ~m) | (d & m);
    endfunction

    function automatic logic [31:0] loadValue(input logic [31:0] w, input logic [31:0] off,
                                              input int sz, input logic unsignedLd);
        logic [31:0] v;
        v = w >> {off[1:0], 3'b000};
        if (sz == 1) return unsignedLd ? {24'b0, v[7:0]} : {{24{v[7]}}, v[7:0]};
        if (sz == 2) return unsignedLd ? {16'b0, v[15:0]} : {{16{v[15]}}, v[15:0]};
        return w;
    endfunction

    function automatic logic [3:0] expByteEn(input int sz, input logic [31:0] off);
        logic [3:0] m;
        m = (sz == 1) ? 4'b0001 : (sz == 2) ? 4'b0011 : 4'b1111;
        return m << off[1:0];
    endfunction

    function automatic logic [31:0] expWrite(input int sz, input logic [31:0] wd);
        if (sz == 1) return {4{wd[7:0]}};
        if (sz == 2) return {2{wd[15:0]}};
        return wd;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalChecks++;
        if (act !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Environment memory: synchronous read, byte-enabled write.
    logic [31:0] benchMem [1024];
    logic benchInit = 1'b0;
    always @(posedge clk) begin
        if (!benchInit) begin
            for (int i = 0; i < 1024; i++) benchMem[i] <= initWord(i);
            benchInit <= 1'b1;
        end else if (!memReWeb) begin
            for (int b = 0; b < 4; b++)
                if (memByteEn[b]) benchMem[memAddr][8*b +: 8] <= memWriteData[8*b +: 8];
        end
        memRdata <= benchMem[memAddr];
    end

    // Reference model: mPhase counts cycles since accept
    // (0 = free, 1 = access cycle, 2 = response cycle, 3 = fault response).
    logic [31:0] refMem [1024];
    logic refInit = 1'b0;
    int mPhase = 0;
    logic        mStore = 1'b0;
    logic [2:0]  mF3 = 3'b0;
    logic [31:0] mOff = 32'b0;
    logic [31:0] mWdata = 32'b0;
    int          mSize = 0;
    logic [31:0] expRdata = 32'b0;
    logic [9:0]  expAddr = 10'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mPhase <= 0;
            expRdata <= 32'b0;
            expAddr <= 10'b0;
            if (!refInit) begin
                for (int i = 0; i < 1024; i++) refMem[i] <= initWord(i);
                refInit <= 1'b1;
            end
        end else begin
            case (mPhase)
                0: if (lsuValid) begin
                    mStore <= lsuIsStore;
                    mF3    <= lsuFunct3;
                    mOff   <= lsuAddr - BASE;
                    mWdata <= lsuWdata;
                    mSize  <= accessSize(lsuIsStore, lsuFunct3);
                    if (reqLegal(lsuIsStore, lsuFunct3, lsuAddr - BASE)) begin
                        mPhase <= 1;
                        expAddr <= 10'((lsuAddr - BASE) >> 2);
                    end else begin
                        mPhase <= 3;
                    end
                end
                1: begin
                    if (mStore) refMem[mOff[11:2]] <= storeMerge(refMem[mOff[11:2]], mOff, mSize, mWdata);
                    mPhase <= 2;
                end
                2: begin
                    if (!mStore) expRdata <= loadValue(refMem[mOff[11:2]], mOff, mSize, mF3[2]);
                    mPhase <= 0;
                end
                default: mPhase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chkOn) begin
            checkOutput("ready", 32'(outReady), 32'(mPhase == 0));
            checkOutput("done", 32'(outDone), 32'(mPhase == 2 || mPhase == 3));
            checkOutput("err", 32'(outErr), 32'(mPhase == 3));
            checkOutput("rdata", outRdata, expRdata);
            checkOutput("mem_addr", 32'(memAddr), 32'(expAddr));
            checkOutput("re_web", 32'(memReWeb), 32'(!(mPhase == 1 && mStore)));
            checkOutput("byte_en", 32'(memByteEn), (mPhase == 1) ? 32'(expByteEn(mSize, mOff)) : 32'd0);
            if (mPhase == 1 && mStore)
                checkOutput("write_data", memWriteData, expWrite(mSize, mWdata));
        end
    end

    // Presents one request just after a rising edge and holds it for one edge.
    task automatic applyStimulus(input logic st, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd);
        lsuValid = 1'b1;
        lsuIsStore = st;
        lsuFunct3 = f3;
        lsuAddr = a;
        lsuWdata = wd;
        @(posedge clk);
        #1;
        lsuValid = 1'b0;
    endtask

    task automatic finishLegal();
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int doneCount;
        int sel;
        logic [31:0] a;
        logic [2:0] f3;
        logic st;
        int memBad;

        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ready", 32'(outReady), 32'd1);
        checkOutput("rst_done", 32'(outDone), 32'd0);
        checkOutput("rst_err", 32'(outErr), 32'd0);
        checkOutput("rst_rdata", outRdata, 32'd0);
        checkOutput("rst_mem_addr", 32'(memAddr), 32'd0);
        checkOutput("rst_re_web", 32'(memReWeb), 32'd1);
        checkOutput("rst_byte_en", 32'(memByteEn), 32'd0);
        checkOutput("rst_write_data", memWriteData, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chkOn = 1'b1;

        applyStimulus(1'b1, 3'b010, 32'h08, 32'hDEAD_BEEF);
        @(negedge clk);
        checkOutput("sw_mem_addr", 32'(memAddr), 32'd2);
        checkOutput("sw_re_web", 32'(memReWeb), 32'd0);
        checkOutput("sw_byte_en", 32'(memByteEn), 32'hF);
        checkOutput("sw_write_data", memWriteData, 32'hDEAD_BEEF);
        checkOutput("sw_done_early", 32'(outDone), 32'd0);
        @(negedge clk);
        checkOutput("sw_done", 32'(outDone), 32'd1);
        @(posedge clk);
        #1;

        applyStimulus(1'b1, 3'b000, 32'h0D, 32'h0000_00A5);
        @(negedge clk);
        checkOutput("sb_mem_addr", 32'(memAddr), 32'd3);
        checkOutput("sb_byte_en", 32'(memByteEn), 32'b0010);
        checkOutput("sb_write_data", memWriteData, 32'hA5A5_A5A5);
        @(negedge clk);
        @(posedge clk);
        #1;

        applyStimulus(1'b1, 3'b001, 32'h0E, 32'h0000_1234);
        @(negedge clk);
        checkOutput("sh_byte_en", 32'(memByteEn), 32'b1100);
        checkOutput("sh_write_data", memWriteData, 32'h1234_1234);
        @(negedge clk);
        @(posedge clk);
        #1;

        applyStimulus(1'b1, 3'b010, 32'h0C, 32'h80FF_1234);
        finishLegal();
        applyStimulus(1'b0, 3'b000, 32'h0F, 32'h0);
        finishLegal();
        checkOutput("lb_rdata", outRdata, 32'hFFFF_FF80);
        applyStimulus(1'b0, 3'b100, 32'h0F, 32'h0);
        finishLegal();
        checkOutput("lbu_rdata", outRdata, 32'h0000_0080);
        applyStimulus(1'b0, 3'b001, 32'h0C, 32'h0);
        finishLegal();
        checkOutput("lh_rdata", outRdata, 32'h0000_1234);

        applyStimulus(1'b0, 3'b010, 32'h02, 32'h0);
        @(negedge clk);
        checkOutput("mis_done", 32'(outDone), 32'd1);
        checkOutput("mis_err", 32'(outErr), 32'd1);
        checkOutput("mis_byte_en", 32'(memByteEn), 32'd0);
        checkOutput("mis_re_web", 32'(memReWeb), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("mis_rdata", outRdata, 32'h0000_1234);

        applyStimulus(1'b0, 3'b010, 32'h1000, 32'h0);
        @(negedge clk);
        checkOutput("oob_done", 32'(outDone), 32'd1);
        checkOutput("oob_err", 32'(outErr), 32'd1);
        checkOutput("oob_byte_en", 32'(memByteEn), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("oob_rdata", outRdata, 32'h0000_1234);

        lsuValid = 1'b1;
        lsuIsStore = 1'b0;
        lsuFunct3 = 3'b010;
        lsuAddr = 32'h0C;
        doneCount = 0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            checkOutput($sformatf("b2b_ready%0d", k), 32'(outReady), 32'(k % 3 == 0));
            if (outDone) doneCount++;
        end
        checkOutput("b2b_dones", 32'(doneCount), 32'd3);
        checkOutput("b2b_rdata", outRdata, 32'h80FF_1234);
        @(posedge clk);
        #1;
        lsuValid = 1'b0;

        applyStimulus(1'b1, 3'b010, 32'h20, 32'hCAFE_F00D);
        @(negedge clk);
        checkOutput("abort_re_web_before", 32'(memReWeb), 32'd0);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("abort_re_web", 32'(memReWeb), 32'd1);
        checkOutput("abort_byte_en", 32'(memByteEn), 32'd0);
        checkOutput("abort_ready", 32'(outReady), 32'd1);
        checkOutput("abort_done", 32'(outDone), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("abort_ready_after", 32'(outReady), 32'd1);
        @(negedge clk);
        checkOutput("abort_no_done", 32'(outDone), 32'd0);
        checkOutput("abort_mem_word", benchMem[8], initWord(8));

        @(posedge clk);
        #1;
        for (int c = 0; c < 1500; c++) begin
            lsuValid = ($urandom_range(0, 9) < 7);
            st = $urandom_range(0, 1) == 1;
            lsuIsStore = st;
            sel = $urandom_range(0, 15);
            if (sel < 11) a = 32'($urandom_range(0, 127));
            else if (sel < 13) a = 32'h0F00 + 32'($urandom_range(0, 511));
            else if (sel == 13) a = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
            else a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            lsuAddr = a;
            if ($urandom_range(0, 4) != 0) begin
                if (st) f3 = 3'($urandom_range(0, 2));
                else begin
                    sel = $urandom_range(0, 4);
                    f3 = (sel == 3) ? 3'd4 : (sel == 4) ? 3'd5 : 3'(sel);
                end
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            lsuFunct3 = f3;
            lsuWdata = $urandom;
            @(posedge clk);
            #1;
        end
        lsuValid = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        memBad = 0;
        for (int i = 0; i < 1024; i++)
            if (benchMem[i] !== refMem[i]) memBad++;
        checkOutput("mem_image_mismatches", 32'(memBad), 32'd0);

        chkOn = 1'b0;
        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
